// File: rtl/io_arb_pkg.sv
// Shared types, constants and the winner-pick function for the IO port arbiter.
package io_arb_pkg;

    typedef enum logic {IDLE = 1'b0, GNT = 1'b1} state_t;

    typedef logic mid_t;
    localparam mid_t M0 = 1'b0;
    localparam mid_t M1 = 1'b1;

    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;

    localparam int IO_AW      = 17;
    localparam int SW_SEL_BIT = 16;

    typedef struct packed {
        logic             wren;
        logic [IO_AW-1:0] address;
        logic [31:0]      data;
        logic [2:0]       funct3;
    } io_req_t;

    // Plain arbitration; the M1 lock override is applied by the caller.
    function automatic mid_t rr_pick(input logic req0, input logic req1,
                                     input mid_t last, input logic fair);
        if (req0 && !req1) return M0;
        if (req1 && !req0) return M1;
        if (fair)          return (last == M0) ? M1 : M0;
        return M0;
    endfunction

endpackage

// File: rtl/io_port_arbiter_if.sv
// Master-side and IO-side signals of the arbiter; slave = arbiter view, master = environment view.
interface io_port_arbiter_if;
    import io_arb_pkg::*;

    logic             i_m0_req,     i_m1_req;
    logic             i_m0_wren,    i_m1_wren;
    logic [IO_AW-1:0] i_m0_address, i_m1_address;
    logic [31:0]      i_m0_data,    i_m1_data;
    logic [2:0]       i_m0_funct3,  i_m1_funct3;
    logic             i_m1_lock;
    logic             o_m0_gnt,     o_m1_gnt;
    logic             o_m0_rvalid,  o_m1_rvalid;
    logic [31:0]      o_rdata;
    logic             o_io_wren;
    logic [IO_AW-1:0] o_io_address;
    logic [31:0]      o_io_data;
    logic [2:0]       o_io_funct3;
    logic [31:0]      i_io_rdata;

    modport slave (
        input  i_m0_req, i_m1_req, i_m0_wren, i_m1_wren,
        input  i_m0_address, i_m1_address, i_m0_data, i_m1_data,
        input  i_m0_funct3, i_m1_funct3, i_m1_lock, i_io_rdata,
        output o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_rdata,
        output o_io_wren, o_io_address, o_io_data, o_io_funct3
    );

    modport master (
        output i_m0_req, i_m1_req, i_m0_wren, i_m1_wren,
        output i_m0_address, i_m1_address, i_m0_data, i_m1_data,
        output i_m0_funct3, i_m1_funct3, i_m1_lock, i_io_rdata,
        input  o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_rdata,
        input  o_io_wren, o_io_address, o_io_data, o_io_funct3
    );

endinterface

// File: rtl/io_port_arbiter.sv
// Two-master arbiter for the memory-mapped IO port: registered grants, round-robin
// or M0-priority, bounded M1 lock, registered load data return.
module io_port_arbiter
    import io_arb_pkg::*;
#(
    parameter bit          FAIR     = 1'b1,
    parameter int unsigned MAX_LOCK = 4
) (
    input logic               i_clk,
    input logic               i_rst,
    io_port_arbiter_if.slave  bus
);

    localparam logic [3:0] MAX_LK = 4'(MAX_LOCK);

    state_t     state;
    mid_t       owner;
    mid_t       last;
    logic [3:0] lock_cnt;
    io_req_t    io_q;
    logic       gnt0, gnt1;
    logic       rv0, rv1;
    logic [31:0] rdata;

    io_req_t m0_p, m1_p, win_p;
    mid_t    win;
    logic    both;

    assign m0_p = '{wren: bus.i_m0_wren, address: bus.i_m0_address,
                    data: bus.i_m0_data, funct3: bus.i_m0_funct3};
    assign m1_p = '{wren: bus.i_m1_wren, address: bus.i_m1_address,
                    data: bus.i_m1_data, funct3: bus.i_m1_funct3};
    assign both = bus.i_m0_req & bus.i_m1_req;

    // Lock overrides fairness; an exhausted lock hands the port back to M0.
    always_comb begin
        win = rr_pick(bus.i_m0_req, bus.i_m1_req, last, FAIR);
        if (both && lock_cnt != 4'd0)  win = M1;
        if (both && lock_cnt == MAX_LK) win = M0;
        win_p = (win == M1) ? m1_p : m0_p;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= IDLE;
            owner    <= M0;
            last     <= M1;
            lock_cnt <= 4'd0;
            io_q     <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rv0      <= 1'b0;
            rv1      <= 1'b0;
            rdata    <= 32'd0;
        end else begin
            rv0 <= 1'b0;
            rv1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_m0_req || bus.i_m1_req) begin
                        state <= GNT;
                        owner <= win;
                        gnt0  <= (win == M0);
                        gnt1  <= (win == M1);
                        io_q  <= win_p;
                    end
                end
                GNT: begin
                    state <= IDLE;
                    last  <= owner;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    io_q  <= '0;
                    if (!io_q.wren) begin
                        rdata <= bus.i_io_rdata;
                        rv0   <= (owner == M0);
                        rv1   <= (owner == M1);
                    end
                    if (owner == M1) begin
                        if (bus.i_m1_lock)
                            lock_cnt <= (lock_cnt >= MAX_LK) ? MAX_LK : lock_cnt + 4'd1;
                        else
                            lock_cnt <= 4'd0;
                    end else begin
                        lock_cnt <= 4'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_m0_gnt     = gnt0;
    assign bus.o_m1_gnt     = gnt1;
    assign bus.o_m0_rvalid  = rv0;
    assign bus.o_m1_rvalid  = rv1;
    assign bus.o_rdata      = rdata;
    assign bus.o_io_wren    = io_q.wren;
    assign bus.o_io_address = io_q.address;
    assign bus.o_io_data    = io_q.data;
    assign bus.o_io_funct3  = io_q.funct3;

endmodule

// File: tb/tb_io_port_arbiter.sv
// Directed bench: FAIR=1 instance is the main target, a FAIR=0 copy shares its stimulus.
module tb_io_port_arbiter;
    import io_arb_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    io_port_arbiter_if bus ();
    io_port_arbiter_if bus_p ();

    io_port_arbiter #(.FAIR(1'b1), .MAX_LOCK(4)) dut   (.i_clk(i_clk), .i_rst(i_rst), .bus(bus.slave));
    io_port_arbiter #(.FAIR(1'b0), .MAX_LOCK(4)) dut_p (.i_clk(i_clk), .i_rst(i_rst), .bus(bus_p.slave));

    assign bus_p.i_m0_req     = bus.i_m0_req;
    assign bus_p.i_m1_req     = bus.i_m1_req;
    assign bus_p.i_m0_wren    = bus.i_m0_wren;
    assign bus_p.i_m1_wren    = bus.i_m1_wren;
    assign bus_p.i_m0_address = bus.i_m0_address;
    assign bus_p.i_m1_address = bus.i_m1_address;
    assign bus_p.i_m0_data    = bus.i_m0_data;
    assign bus_p.i_m1_data    = bus.i_m1_data;
    assign bus_p.i_m0_funct3  = bus.i_m0_funct3;
    assign bus_p.i_m1_funct3  = bus.i_m1_funct3;
    assign bus_p.i_m1_lock    = bus.i_m1_lock;
    assign bus_p.i_io_rdata   = bus.i_io_rdata;

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    int unsigned exp_fair [4] = '{0, 1, 0, 1};
    int unsigned exp_lock [7] = '{0, 1, 1, 1, 1, 0, 1};

    initial begin
        bus.i_m0_req = 0; bus.i_m1_req = 0; bus.i_m0_wren = 0; bus.i_m1_wren = 0;
        bus.i_m0_address = '0; bus.i_m1_address = '0; bus.i_m0_data = '0; bus.i_m1_data = '0;
        bus.i_m0_funct3 = SB; bus.i_m1_funct3 = SB; bus.i_m1_lock = 0; bus.i_io_rdata = '0;

        // Reset state
        tick(); tick();
        chk("rst_gnt0",   32'(bus.o_m0_gnt), 0);
        chk("rst_gnt1",   32'(bus.o_m1_gnt), 0);
        chk("rst_rv",     32'({bus.o_m0_rvalid, bus.o_m1_rvalid}), 0);
        chk("rst_rdata",  bus.o_rdata, 0);
        chk("rst_iowren", 32'(bus.o_io_wren), 0);
        chk("rst_ioaddr", 32'(bus.o_io_address), 0);
        i_rst = 1'b1;
        tick();

        // M0 byte store
        bus.i_m0_req = 1; bus.i_m0_wren = 1; bus.i_m0_address = 17'h00000;
        bus.i_m0_data = 32'hA5; bus.i_m0_funct3 = SB;
        tick();
        chk("st_gnt0",   32'(bus.o_m0_gnt), 1);
        chk("st_gnt1",   32'(bus.o_m1_gnt), 0);
        chk("st_wren",   32'(bus.o_io_wren), 1);
        chk("st_addr",   32'(bus.o_io_address), 0);
        chk("st_data",   bus.o_io_data, 32'hA5);
        chk("st_f3",     32'(bus.o_io_funct3), 32'(SB));
        tick();
        bus.i_m0_req = 0; bus.i_m0_wren = 0;
        chk("st_done_gnt", 32'(bus.o_m0_gnt), 0);
        chk("st_no_rv",    32'(bus.o_m0_rvalid), 0);
        chk("idle_wren",   32'(bus.o_io_wren), 0);
        chk("idle_data",   bus.o_io_data, 0);
        tick();
        chk("idle_nognt",  32'({bus.o_m0_gnt, bus.o_m1_gnt}), 0);

        // M1 load from switches
        bus.i_m1_req = 1; bus.i_m1_wren = 0; bus.i_m1_address = 17'h10000;
        bus.i_io_rdata = 32'h0000_1234;
        tick();
        chk("ld_gnt1", 32'(bus.o_m1_gnt), 1);
        chk("ld_gnt0", 32'(bus.o_m0_gnt), 0);
        chk("ld_addr", 32'(bus.o_io_address), 32'h10000);
        chk("ld_wren", 32'(bus.o_io_wren), 0);
        tick();
        bus.i_m1_req = 0;
        chk("ld_rv1",   32'(bus.o_m1_rvalid), 1);
        chk("ld_rv0",   32'(bus.o_m0_rvalid), 0);
        chk("ld_rdata", bus.o_rdata, 32'h1234);
        bus.i_io_rdata = 32'hDEAD_BEEF;
        tick();
        chk("ld_rv1_end", 32'(bus.o_m1_rvalid), 0);
        chk("ld_hold",    bus.o_rdata, 32'h1234);

        // Contention, both loads; FAIR alternates, priority copy sticks to M0
        bus.i_m0_address = 17'h01000; bus.i_m1_address = 17'h02000;
        bus.i_m0_req = 1; bus.i_m1_req = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("fair_g0_%0d", i), 32'(bus.o_m0_gnt), 32'(exp_fair[i] == 0));
            chk($sformatf("fair_g1_%0d", i), 32'(bus.o_m1_gnt), 32'(exp_fair[i] == 1));
            chk($sformatf("fair_ad_%0d", i), 32'(bus.o_io_address),
                exp_fair[i] == 0 ? 32'h01000 : 32'h02000);
            chk($sformatf("prio_g0_%0d", i), 32'(bus_p.o_m0_gnt), 1);
            chk($sformatf("prio_g1_%0d", i), 32'(bus_p.o_m1_gnt), 0);
            tick();
            chk($sformatf("gap_%0d", i), 32'({bus.o_m0_gnt, bus.o_m1_gnt}), 0);
        end

        // M1 lock: four locked M1 grants, then M0 breaks in
        bus.i_m1_lock = 1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("lock_g0_%0d", i), 32'(bus.o_m0_gnt), 32'(exp_lock[i] == 0));
            chk($sformatf("lock_g1_%0d", i), 32'(bus.o_m1_gnt), 32'(exp_lock[i] == 1));
            tick();
            if (i == 5) chk("lock_cnt_clr", 32'(dut.lock_cnt), 0);
        end
        bus.i_m0_req = 0; bus.i_m1_req = 0; bus.i_m1_lock = 0;
        tick();

        // M0-only load so the tie pointer would favour M1 without a reset
        bus.i_m0_req = 1; bus.i_m0_wren = 0;
        tick();
        chk("pre_g0", 32'(bus.o_m0_gnt), 1);
        tick();
        // Reset lands in the gnt cycle of an M0 store
        bus.i_m0_wren = 1; bus.i_m0_data = 32'h55;
        tick();
        chk("rg_gnt0", 32'(bus.o_m0_gnt), 1);
        i_rst = 1'b0;
        #1;
        chk("rg_gnt_drop",  32'(bus.o_m0_gnt), 0);
        chk("rg_wren_drop", 32'(bus.o_io_wren), 0);
        tick();
        i_rst = 1'b1;
        bus.i_m1_req = 1; bus.i_m1_wren = 1;
        tick();
        chk("post_tie_g0", 32'(bus.o_m0_gnt), 1);
        chk("post_tie_g1", 32'(bus.o_m1_gnt), 0);
        tick();
        bus.i_m0_req = 0; bus.i_m1_req = 0;
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
